sram_burst_top: RTL and testbench



---
 rtl/sram_burst_top.sv | 165 ++++++++++++++++
 tb/tb_sram_burst_top.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_top.sv
// Serially loaded word array with single/burst reads and writes and address wrap-around.
// Optional stored even parity with a par_err output is enabled by defining PARITY_EN.
`timescale 1ns/1ps
module sram_burst_top #(
  parameter int unsigned ROWS      = 16,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SER_W     = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [SER_W-1:0]             serial_in,
  input  logic                         shift,
  input  logic                         w_en,
  input  logic                         r_en,
  input  logic [$clog2(ROWS)-1:0]      addr,
  input  logic [$clog2(MAX_BURST):0]   burst_len,
  output logic                         word_ready,
  output logic                         busy,
  output logic                         data_valid,
  output logic [COLS-1:0]              data_out
`ifdef PARITY_EN
  ,
  output logic                         par_err
`endif
);

  localparam int unsigned AW  = $clog2(ROWS);
  localparam int unsigned BLW = $clog2(MAX_BURST) + 1;
  localparam int unsigned NCH = COLS / SER_W;
  localparam int unsigned CW  = $clog2(NCH + 1);
`ifdef PARITY_EN
  localparam int unsigned MW  = COLS + 1;
`else
  localparam int unsigned MW  = COLS;
`endif

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [BLW-1:0]  rem_q, rem_d;
  logic [COLS-1:0] ld_q, ld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            word_ready_q, word_ready_d;
  logic            data_valid_q;
  logic [COLS-1:0] data_out_q;
  logic [BLW-1:0]  bl_c;
  logic            mem_we, rd_en, consume;
  logic [AW-1:0]   mem_waddr;
  logic [MW-1:0]   mem_wdata;
  logic [MW-1:0]   mem [ROWS];

  // Explicit wrap so non-power-of-2 depths never address past the last row.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(ROWS - 1)) ? '0 : p + AW'(1);
  endfunction

  assign bl_c = (burst_len >= BLW'(MAX_BURST)) ? BLW'(MAX_BURST - 1) : burst_len;

`ifdef PARITY_EN
  assign mem_wdata = {^ld_q, ld_q};
`else
  assign mem_wdata = ld_q;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    mem_we       = 1'b0;
    mem_waddr    = addr;
    rd_en        = 1'b0;
    consume      = 1'b0;
    ld_d         = ld_q;
    cnt_d        = cnt_q;
    word_ready_d = word_ready_q;

    unique case (state_q)
      StIdle: begin
        if (w_en && word_ready_q) begin
          mem_we  = 1'b1;
          consume = 1'b1;
          if (bl_c != '0) begin
            state_d = StWrBurst;
            rem_d   = bl_c;
            ptr_d   = ptr_inc(addr);
          end
        end else if (r_en) begin
          state_d = StRdBurst;
          ptr_d   = addr;
          rem_d   = bl_c;
        end
      end
      StWrBurst: begin
        if (word_ready_q) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          consume   = 1'b1;
          ptr_d     = ptr_inc(ptr_q);
          rem_d     = rem_q - BLW'(1);
          if (rem_q == BLW'(1)) state_d = StIdle;
        end
      end
      StRdBurst: begin
        rd_en = 1'b1;
        ptr_d = ptr_inc(ptr_q);
        rem_d = rem_q - BLW'(1);
        if (rem_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (consume) begin
      word_ready_d = 1'b0;
      cnt_d        = '0;
    end else if (shift && !word_ready_q) begin
      ld_d  = (ld_q << SER_W) | COLS'(serial_in);
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(NCH)) word_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      rem_q        <= '0;
      ld_q         <= '0;
      cnt_q        <= '0;
      word_ready_q <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      ld_q         <= ld_d;
      cnt_q        <= cnt_d;
      word_ready_q <= word_ready_d;
      data_valid_q <= rd_en;
      if (rd_en) data_out_q <= mem[ptr_q][COLS-1:0];
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) par_err_q <= 1'b0;
    else      par_err_q <= rd_en && (^mem[ptr_q]);
  end
  assign par_err = par_err_q;
`endif

  assign word_ready = word_ready_q;
  assign busy       = (state_q != StIdle);
  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_sram_burst_top.sv
// Directed bench for sram_burst_top: stimulus pushes expected read words into a queue and a
// negedge monitor pops and compares whenever data_valid is high.
`timescale 1ns/1ps
module tb_sram_burst_top;

  logic       clk;
  logic       arst;
  logic [0:0] serial_in;
  logic       shift;
  logic       w_en;
  logic       r_en;
  logic [3:0] addr;
  logic [2:0] burst_len;
  logic       word_ready;
  logic       busy;
  logic       data_valid;
  logic [7:0] data_out;
`ifdef PARITY_EN
  logic       par_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  sram_burst_top #(
    .ROWS      (16),
    .COLS      (8),
    .SER_W     (1),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .serial_in  (serial_in),
    .shift      (shift),
    .w_en       (w_en),
    .r_en       (r_en),
    .addr       (addr),
    .burst_len  (burst_len),
    .word_ready (word_ready),
    .busy       (busy),
    .data_valid (data_valid),
    .data_out   (data_out)
`ifdef PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!arst && data_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got data_out=%02h with empty queue", data_out);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (data_out !== e) begin
          n_err++;
          $display("FAIL read_data: got %02h expected %02h", data_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      serial_in = w[i];
      shift     = 1'b1;
      tick();
    end
    shift     = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic do_write(input int a, input int bl);
    w_en      = 1'b1;
    addr      = 4'(a);
    burst_len = 3'(bl);
    tick();
    w_en      = 1'b0;
  endtask

  // Caller pushes the expected words; checks latency, gapless valid and return to idle.
  task automatic do_read(input int a, input int bl, input int nwords, input logic also_w);
    r_en      = 1'b1;
    w_en      = also_w;
    addr      = 4'(a);
    burst_len = 3'(bl);
    tick();
    r_en      = 1'b0;
    w_en      = 1'b0;
    check("rd_busy", busy, 1);
    check("rd_latency", data_valid, 0);
    for (int i = 0; i < nwords; i++) begin
      tick();
      check("rd_valid", data_valid, 1);
    end
    tick();
    check("rd_valid_drop", data_valid, 0);
    check("rd_busy_drop", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    arst      = 1'b1;
    serial_in = 1'b0;
    shift     = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    addr      = '0;
    burst_len = '0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_word_ready", word_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_data_out", data_out, 0);
    end

    // Serial load of A5; ninth shift must be ignored.
    for (int i = 7; i >= 0; i--) begin
      serial_in = 1'(8'hA5 >> i);
      shift     = 1'b1;
      tick();
      if (i > 0) check("load_partial", word_ready, 0);
    end
    check("load_full", word_ready, 1);
    serial_in = 1'b1;
    tick();
    shift     = 1'b0;
    check("load_ignored", word_ready, 1);
    do_write(3, 0);
    check("single_wr_busy", busy, 0);
    check("single_wr_clear", word_ready, 0);
    exp_q.push_back(8'hA5);
    do_read(3, 0, 1, 1'b0);

    // Burst write with wrap 14,15,0,1.
    shift_word(8'h11);
    do_write(14, 3);
    check("bw_busy", busy, 1);
    check("bw_clear", word_ready, 0);
    shift_word(8'h22);
    tick();
    shift_word(8'h33);
    tick();
    check("bw_busy_mid", busy, 1);
    shift_word(8'h44);
    tick();
    check("bw_done", busy, 0);
    check("bw_clear_last", word_ready, 0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    do_read(14, 3, 4, 1'b0);

    // w_en and r_en together with a word loaded: write wins.
    shift_word(8'h5A);
    w_en      = 1'b1;
    r_en      = 1'b1;
    addr      = 4'd7;
    burst_len = 3'd0;
    tick();
    w_en      = 1'b0;
    r_en      = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_clear", word_ready, 0);
    tick();
    check("prio_no_read", data_valid, 0);
    exp_q.push_back(8'h5A);
    do_read(7, 0, 1, 1'b0);
    // No word loaded: read is accepted.
    exp_q.push_back(8'hA5);
    do_read(3, 0, 1, 1'b1);

    // Reset in the middle of a read burst.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    r_en      = 1'b1;
    addr      = 4'd14;
    burst_len = 3'd3;
    tick();
    r_en      = 1'b0;
    tick();
    check("abort_w0", data_valid, 1);
    tick();
    check("abort_w1", data_valid, 1);
    @(negedge clk);
    #1 arst = 1'b1;
    #1;
    check("abort_valid", data_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", data_out, 0);
    check("abort_drained", exp_q.size(), 0);
    @(posedge clk);
    #1 arst = 1'b0;

    // Oversized burst_len clamps to four words; contents survive reset.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    do_read(14, 7, 4, 1'b0);

`ifdef PARITY_EN
    shift_word(8'h3C);
    do_write(5, 0);
    dut.mem[5] = dut.mem[5] ^ 9'h001;
    exp_q.push_back(8'h3D);
    r_en      = 1'b1;
    addr      = 4'd5;
    burst_len = 3'd0;
    tick();
    r_en      = 1'b0;
    tick();
    check("par_valid", data_valid, 1);
    check("par_err_set", par_err, 1);
    tick();
    exp_q.push_back(8'h5A);
    r_en      = 1'b1;
    addr      = 4'd7;
    tick();
    r_en      = 1'b0;
    tick();
    check("par_clean_valid", data_valid, 1);
    check("par_err_clear", par_err, 0);
    tick();
`endif

    repeat (2) tick();
    check("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
